// File: rtl/multiplier2.sv
// rtl/multiplier2.sv - sequential shift-add multiplier, one result per WIDTH+2 cycles
// Optional signed support is compiled in with `define MULT2_SIGNED_EN.
module multiplier2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef MULT2_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic [2*WIDTH-1:0] Product,
    output logic               ready,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] result;

`ifdef MULT2_SIGNED_EN
    logic neg_q;

    // Magnitudes stay unsigned in WIDTH bits, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (signed_mode && A[WIDTH-1]) begin
            a_mag = (~A) + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        if (signed_mode && B[WIDTH-1]) begin
            b_mag = (~B) + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        result = acc;
        if (neg_q) begin
            result = (~acc) + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_q <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
        end
    end
`else
    always_comb begin
        a_mag  = A;
        b_mag  = B;
        result = acc;
    end
`endif

    assign ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            Product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    Product <= result;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/multiplier2.md
MULTIPLIER2 -- requirements
Module: multiplier2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), iteration counter width (derived, not overridden).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only while ready=1.
REQ-006 SHALL have port A  input  WIDTH  multiplicand, captured on accepted start.
REQ-007 SHALL have port B  input  WIDTH  multiplier, captured on accepted start.
REQ-008 SHALL have port signed_mode  input  1  1 = A/B/Product two's complement; present only when MULT2_SIGNED_EN is defined.
REQ-009 SHALL have port Product  output  2*WIDTH  registered result.
REQ-010 SHALL have port ready  output  1  idle, Product valid, start accepted.
REQ-011 SHALL have port done  output  1  one-cycle pulse on completion.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> FIN -> IDLE; ready=1 only in IDLE.
REQ-013 SHALL accept start at posedge k when ready=1: capture A, B, signed_mode; clear accumulator; counter=0; go CALC.
REQ-014 SHALL perform one shift-add step per cycle in CALC, exactly WIDTH steps, then go FIN.
REQ-015 SHALL, in FIN, write Product, pulse done=1, return to IDLE; ready=1 and Product valid after posedge k+WIDTH+1 (9 cycles at WIDTH=8).
REQ-016 SHALL ignore start and A/B/signed_mode changes while ready=0; operands may be X after capture edge.
REQ-017 SHALL hold Product unchanged from FIN until the next FIN; no intermediate values visible on Product.
REQ-018 SHALL accept back-to-back start in the first IDLE cycle after FIN (throughput one result per WIDTH+2 cycles).
REQ-019 SHALL compute unsigned Product = A*B exactly in 2*WIDTH bits, no truncation or overflow.
REQ-020 SHALL drive done=0 in all cycles except the single cycle after the FIN edge.

Reset
REQ-021 SHALL, on rst_n=0, immediately force IDLE, Product=0, ready=1, done=0, counter=0, accumulator=0, independent of clk.
REQ-022 SHALL abort any in-progress operation on reset with no partial Product update.
REQ-023 SHALL ignore start in the cycle rst_n deasserts unless rst_n is sampled high at that edge.

Configuration
REQ-024 SHALL use macro MULT2_SIGNED_EN to compile signed support in or out.
REQ-025 SHALL, with MULT2_SIGNED_EN defined and signed_mode=1, convert operands to magnitudes at capture and negate result in FIN when signs differ; latency per REQ-015 unchanged.
REQ-026 SHALL, with MULT2_SIGNED_EN defined and signed_mode=0, behave as REQ-019.
REQ-027 SHALL, without MULT2_SIGNED_EN, omit the signed_mode port and all sign logic; unsigned only.
REQ-028 SHALL handle signed -2^(WIDTH-1) operands correctly (magnitude held in WIDTH bits unsigned).

Verification
REQ-029 SHALL verify WIDTH=8 unsigned: A=0xFF, B=0xFF -> Product=0xFE01, done pulse and ready=1 exactly 9 edges after start edge; A=0x00, B=0xA5 -> 0x0000.
REQ-030 SHALL verify MULT2_SIGNED_EN, signed_mode=1: A=0x80, B=0x80 -> 0x4000; A=0xFD, B=0x05 -> 0xFFF1; same operands signed_mode=0 -> 0x4000 and 0x04F1.
REQ-031 SHALL verify start held high with new A=0x12,B=0x34 during CALC of 0x03*0x04 -> Product=0x000C, the second request ignored.
REQ-032 SHALL verify rst_n pulsed low in CALC cycle 4 of 0xFF*0xFF -> Product=0, ready=1 immediately; subsequent 0x02*0x03 -> 0x0006.
REQ-033 SHALL verify WIDTH=16: 0xFFFF*0xFFFF -> 0xFFFE0001 after 17 edges; back-to-back 0x0002*0x8000 started first IDLE cycle -> 0x00010000.
REQ-034 SHALL verify 100 random operand pairs per configuration against a behavioural A*B model with zero mismatches.
